// File: rtl/div_pkg.sv
// Shared types and constants for the repetitive-subtraction divider.
// The state encodings are fixed so that status decoders outside this slice keep working.
package div_pkg;

    localparam int unsigned DIV_XLEN_DEFAULT = 16;

    localparam logic [1:0] DIV_ENC_IDLE    = 2'b00;
    localparam logic [1:0] DIV_ENC_CALC    = 2'b01;
    localparam logic [1:0] DIV_ENC_DONE    = 2'b10;
    localparam logic [1:0] DIV_ENC_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = DIV_ENC_IDLE,
        CALC = DIV_ENC_CALC,
        DONE = DIV_ENC_DONE
    } div_state_t;

    // IDLE and DONE both accept a new operation, which is what allows back-to-back use.
    function automatic logic state_can_accept(input div_state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/div_control.sv
// Control FSM for the divider: sequences IDLE -> CALC -> DONE and drives the handshake.
// It decides when to stop subtracting from the datapath's ge flag.
module div_control
    import div_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ld_input_i,
    input  logic       ge_i,
    input  logic       div_zero_i,
    output logic       ready_o,
    output logic       valid_o,
    output logic       accept_o,
    output div_state_t state_o
);

    div_state_t state_q;
    div_state_t state_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ready_o  = 1'b0;
        valid_o  = 1'b0;
        accept_o = 1'b0;

        case (state_q)
            IDLE: begin
                ready_o  = 1'b1;
                accept_o = ld_input_i;
                if (ld_input_i) begin
                    state_d = div_zero_i ? DONE : CALC;
                end
            end
            CALC: begin
                if (!ge_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready_o  = 1'b1;
                valid_o  = 1'b1;
                accept_o = ld_input_i;
                if (ld_input_i) begin
                    state_d = div_zero_i ? DONE : CALC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The illegal code falls through to default above and must never accept a load.
        if (!state_can_accept(state_q)) begin
            accept_o = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/div_datapath.sv
// Datapath for the divider: operand registers, full-width compare/subtract and quotient counter.
// The divisor is zero-extended so the compare and subtract run at the dividend width.
module div_datapath
    import div_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              accept_i,
    input  div_state_t        state_i,
    input  logic [2*XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0]   divisor_i,
    output logic              ge_o,
    output logic              div_zero_o,
    output logic              div_by_zero_o,
    output logic [2*XLEN-1:0] quotient_o,
    output logic [XLEN-1:0]   remainder_o
);

    localparam int unsigned DW = 2 * XLEN;

    logic [DW-1:0]   rem_q;
    logic [DW-1:0]   rem_d;
    logic [DW-1:0]   quot_q;
    logic [DW-1:0]   quot_d;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] dvs_d;
    logic            dbz_q;
    logic            dbz_d;

    logic [DW-1:0]   dvs_ext;

    assign dvs_ext    = {{XLEN{1'b0}}, dvs_q};
    assign ge_o       = (rem_q >= dvs_ext);
    assign div_zero_o = (divisor_i == '0);

    always_comb begin
        rem_d  = rem_q;
        quot_d = quot_q;
        dvs_d  = dvs_q;
        dbz_d  = dbz_q;

        if (accept_i) begin
            rem_d = dividend_i;
            dvs_d = divisor_i;
            if (div_zero_i_q()) begin
                quot_d = '1;
                dbz_d  = 1'b1;
            end else begin
                quot_d = '0;
                dbz_d  = 1'b0;
            end
        end else if ((state_i == CALC) && ge_o) begin
            rem_d  = rem_q - dvs_ext;
            quot_d = quot_q + DW'(1);
        end
    end

    function automatic logic div_zero_i_q();
        return div_zero_o;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvs_q  <= dvs_d;
            dbz_q  <= dbz_d;
        end
    end

    // The final remainder is always below the divisor, so dropping the upper half loses nothing.
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q[XLEN-1:0];
    assign div_by_zero_o = dbz_q;

endmodule

// File: rtl/div.sv
// Unsigned repetitive-subtraction divider: 2*XLEN-bit dividend by XLEN-bit divisor.
// Thin top level that only wires the control FSM to the datapath.
module div
    import div_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ld_input_i,
    input  logic [2*XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0]   divisor_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic              div_by_zero_o,
    output logic [2*XLEN-1:0] quotient_o,
    output logic [XLEN-1:0]   remainder_o
);

    div_state_t state;
    logic       accept;
    logic       ge;
    logic       div_zero;

    div_control u_control (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .ld_input_i (ld_input_i),
        .ge_i       (ge),
        .div_zero_i (div_zero),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .accept_o   (accept),
        .state_o    (state)
    );

    div_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .accept_i      (accept),
        .state_i       (state),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .ge_o          (ge),
        .div_zero_o    (div_zero),
        .div_by_zero_o (div_by_zero_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o)
    );

endmodule
